// File: rtl/word_shift_pkg.sv
// -----------------------------------------------------------------------------
// word_shift_pkg
// Shared definitions for the word-shift link: the receiver state encoding,
// the rotate helpers used by both the transmitter model and the receiver, and
// the counter value the transmitter emits first after its reset.
// No ports (package).
// -----------------------------------------------------------------------------
package word_shift_pkg;

    // First counter value the transmitter sends after its reset.
    localparam logic [7:0] WS_SEED = 8'hfc;

    // Receiver lock state.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } unshift_state_t;

    // Rotate an 8-bit word left by r (taken modulo 8).
    function automatic logic [7:0] rotl_w(input logic [7:0] x, input int unsigned r);
        int unsigned r_m;
        r_m = r % 32'd8;
        if (r_m == 32'd0) begin
            return x;
        end else begin
            return (x << r_m) | (x >> (32'd8 - r_m));
        end
    endfunction

    // Rotate an 8-bit word right by r (taken modulo 8).
    function automatic logic [7:0] rotr_w(input logic [7:0] x, input int unsigned r);
        int unsigned r_m;
        r_m = r % 32'd8;
        if (r_m == 32'd0) begin
            return x;
        end else begin
            return (x >> r_m) | (x << (32'd8 - r_m));
        end
    endfunction

endpackage

// File: rtl/word_unshift_rx_if.sv
// -----------------------------------------------------------------------------
// word_unshift_rx_if
// Bus bundle between the link input, the word_unshift_rx receiver and the
// downstream checker.
//   in_valid / in_data : rotated word from the link (no backpressure)
//   out_valid/ out_data: recovered word
//   locked             : receiver is in LOCKED
//   seq_err            : one-cycle pulse on a mismatch while LOCKED
//   err_cnt            : saturating mismatch count (tied 0 when not built)
// Modports: master = the side feeding the link and observing results,
//           slave  = the receiver itself.
// -----------------------------------------------------------------------------
interface word_unshift_rx_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         locked;
    logic         seq_err;
    logic [7:0]   err_cnt;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data,
        input  locked,
        input  seq_err,
        input  err_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data,
        output locked,
        output seq_err,
        output err_cnt
    );
endinterface

// File: rtl/word_rotr.sv
// -----------------------------------------------------------------------------
// word_rotr
// Combinational right-rotator: o_data = rotr(i_data, ROT).
//   i_data : W-bit input word
//   o_data : W-bit word rotated right by ROT (ROT=0 passes through)
// -----------------------------------------------------------------------------
module word_rotr #(
    parameter int W   = 8,
    parameter int ROT = 5
) (
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    generate
        if (ROT == 0) begin : g_pass
            assign o_data = i_data;
        end else begin : g_rot
            // Low ROT bits wrap around to the top.
            assign o_data = {i_data[ROT-1:0], i_data[W-1:ROT]};
        end
    endgenerate

endmodule

// File: rtl/word_unshift_rx.sv
// -----------------------------------------------------------------------------
// word_unshift_rx
// Receive side of the word-shift link. Undoes the transmitter's left rotation
// and tracks the transmitter's incrementing counter: HUNT seeds the expected
// value from the first word, VERIFY needs LOCK_N consecutive matches to lock,
// LOCKED keeps stepping the expectation through errors and falls back to HUNT
// after LOSS_N consecutive mismatches.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : word_unshift_rx_if.slave (in_valid/in_data in; out_valid/out_data,
//         locked, seq_err, err_cnt out). All outputs are registered, 1-cycle
//         latency from in_valid to out_valid.
//
// Configuration macro:
//   WORD_UNSHIFT_ERRCNT_EN - when defined, builds the saturating err_cnt
//                            register; otherwise err_cnt reads 8'h00.
// -----------------------------------------------------------------------------
module word_unshift_rx
    import word_shift_pkg::*;
#(
    parameter int          W      = 8,
    parameter int          ROT    = 5,
    parameter int unsigned SEED   = 32'(WS_SEED),
    parameter int          LOCK_N = 4,
    parameter int          LOSS_N = 3
) (
    input  logic              clk,
    input  logic              rst,
    word_unshift_rx_if.slave  bus
);

    // The run counter is 3 bits wide and the word is fixed at 8 bits, so
    // reject parameter sets the datapath cannot represent.
    generate
        if ((W != 8) || (ROT < 0) || (ROT >= W) || (LOCK_N < 1) || (LOCK_N > 7) ||
            (LOSS_N < 1) || (LOSS_N > 7) || (SEED > 32'hff)) begin : g_param_check
            $error("word_unshift_rx: unsupported parameter set");
        end
    endgenerate

    localparam logic [3:0] LOCK_N_C = 4'(LOCK_N);
    localparam logic [3:0] LOSS_N_C = 4'(LOSS_N);

    unshift_state_t r_state;
    unshift_state_t w_state_nxt;
    logic [W-1:0]   r_exp;
    logic [W-1:0]   w_exp_nxt;
    logic [2:0]     r_run;
    logic [2:0]     w_run_nxt;
    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic           r_seq_err;

    logic [W-1:0]   w_rec;
    logic [3:0]     w_run_inc;
    logic           w_match;
    logic           w_err_hit;

    word_rotr #(
        .W   (W),
        .ROT (ROT)
    ) u_rotr (
        .i_data (bus.in_data),
        .o_data (w_rec)
    );

    // Widened so run+1 can be compared against LOCK_N/LOSS_N without overflow.
    assign w_run_inc = {1'b0, r_run} + 4'd1;
    assign w_match   = (w_rec == r_exp);

    // Next-state, expected-value and run-length decisions for one valid word.
    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp;
        w_run_nxt   = r_run;
        w_err_hit   = 1'b0;
        if (bus.in_valid) begin
            case (r_state)
                HUNT: begin
                    w_exp_nxt = w_rec + 8'd1;
                    if (LOCK_N == 1) begin
                        w_state_nxt = LOCKED;
                        w_run_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = VERIFY;
                        w_run_nxt   = 3'd1;
                    end
                end
                VERIFY: begin
                    if (w_match) begin
                        w_exp_nxt = r_exp + 8'd1;
                        if (w_run_inc == LOCK_N_C) begin
                            w_state_nxt = LOCKED;
                            w_run_nxt   = 3'd0;
                        end else begin
                            w_run_nxt   = w_run_inc[2:0];
                        end
                    end else begin
                        // Re-seed from this word, same as leaving HUNT.
                        w_exp_nxt = w_rec + 8'd1;
                        if (LOCK_N == 1) begin
                            w_state_nxt = LOCKED;
                            w_run_nxt   = 3'd0;
                        end else begin
                            w_run_nxt   = 3'd1;
                        end
                    end
                end
                LOCKED: begin
                    // Keep stepping even on errors so a single corrupt word
                    // does not desynchronise the following ones.
                    w_exp_nxt = r_exp + 8'd1;
                    if (w_match) begin
                        w_run_nxt = 3'd0;
                    end else begin
                        w_err_hit = 1'b1;
                        if (w_run_inc == LOSS_N_C) begin
                            w_state_nxt = HUNT;
                            w_run_nxt   = 3'd0;
                        end else begin
                            w_run_nxt   = w_run_inc[2:0];
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_exp_nxt   = 8'd0;
                    w_run_nxt   = 3'd0;
                end
            endcase
        end else begin
            w_err_hit = 1'b0;
        end
    end

    // State, tracking registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_exp       <= 8'd0;
            r_run       <= 3'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp       <= w_exp_nxt;
            r_run       <= w_run_nxt;
            r_out_valid <= bus.in_valid;
            r_seq_err   <= w_err_hit;
            if (bus.in_valid) begin
                r_out_data <= w_rec;
            end
        end
    end

`ifdef WORD_UNSHIFT_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of mismatches seen while LOCKED; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'h00;
        end else if (w_err_hit && (r_err_cnt != 8'hff)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`else
    assign bus.err_cnt = 8'h00;
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.locked    = (r_state == LOCKED);
    assign bus.seq_err   = r_seq_err;

endmodule

// File: tb/tb_word_unshift_rx.sv
// -----------------------------------------------------------------------------
// tb_word_unshift_rx
// Self-checking bench for word_unshift_rx (ROT=5, LOCK_N=4, LOSS_N=3).
// Expected values come from directed constants and from a behavioural model
// that recovers words by arithmetic rotation and tracks lock with plain ints.
// -----------------------------------------------------------------------------
module tb_word_unshift_rx;

    localparam int ROT    = 5;
    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;
`ifdef WORD_UNSHIFT_ERRCNT_EN
    localparam bit ERRC_EN = 1'b1;
`else
    localparam bit ERRC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    word_unshift_rx_if #(.W(8)) bus ();

    word_unshift_rx #(
        .W      (8),
        .ROT    (ROT),
        .SEED   (32'hfc),
        .LOCK_N (LOCK_N),
        .LOSS_N (LOSS_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: mode 0 = hunting, 1 = verifying, 2 = locked.
    int m_mode = 0;
    int m_exp  = 0;
    int m_run  = 0;
    bit m_ov   = 1'b0;
    int m_od   = 0;
    bit m_seq  = 1'b0;
    int m_err  = 0;

    // rotr/rotl via a doubled word: {x,x} shifted, low byte kept.
    function automatic int tb_rotr(input int x);
        return ((x * 257) >> ROT) & 255;
    endfunction

    function automatic int tb_rotl(input int x);
        return ((x * 257) >> (8 - ROT)) & 255;
    endfunction

    task automatic model_step(input bit r, input bit v, input int d);
        int rec;
        if (r) begin
            m_mode = 0; m_exp = 0; m_run = 0;
            m_ov = 1'b0; m_od = 0; m_seq = 1'b0; m_err = 0;
        end else begin
            m_ov  = v;
            m_seq = 1'b0;
            if (v) begin
                rec  = tb_rotr(d);
                m_od = rec;
                if (m_mode == 2) begin
                    if (rec == m_exp) begin
                        m_run = 0;
                    end else begin
                        m_seq = 1'b1;
                        if (ERRC_EN && m_err < 255) m_err++;
                        m_run++;
                        if (m_run == LOSS_N) begin
                            m_mode = 0;
                            m_run  = 0;
                        end
                    end
                    m_exp = (m_exp + 1) % 256;
                end else if (m_mode == 1 && rec == m_exp) begin
                    m_exp = (m_exp + 1) % 256;
                    m_run++;
                    if (m_run == LOCK_N) begin
                        m_mode = 2;
                        m_run  = 0;
                    end
                end else begin
                    m_exp  = (rec + 1) % 256;
                    m_run  = 1;
                    m_mode = 1;
                end
            end
        end
    endtask

    // Drive one cycle, sample #1 after the edge, advance the model.
    task automatic drive_cycle(input bit r, input bit v, input int d);
        rst          = r;
        bus.in_valid = v;
        bus.in_data  = d[7:0];
        @(posedge clk);
        #1;
        model_step(r, v, d);
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b0, 0);
        drive_cycle(1'b1, 1'b1, 8'h9f);
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.locked, bus.seq_err, bus.err_cnt} !== 19'd0)
            $display("FAIL reset_state: got ov=%b od=%h lk=%b se=%b ec=%h expected all zero",
                     bus.out_valid, bus.out_data, bus.locked, bus.seq_err, bus.err_cnt);
        else n_pass++;
    endtask

    task automatic test_lock();
        int words[4];
        int outs[4];
        words = '{8'h9f, 8'hbf, tb_rotl(8'hfe), tb_rotl(8'hff)};
        outs  = '{8'hfc, 8'hfd, 8'hfe, 8'hff};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, words[i]);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(outs[i]))
                $display("FAIL lock_data[%0d]: got ov=%b od=%h expected ov=1 od=%h",
                         i, bus.out_valid, bus.out_data, outs[i]);
            else n_pass++;
            n_checks++;
            if (bus.locked !== (i == 3))
                $display("FAIL lock_flag[%0d]: got %b expected %b", i, bus.locked, (i == 3));
            else n_pass++;
        end
        n_checks++;
        if (bus.err_cnt !== 8'h00 || bus.seq_err !== 1'b0)
            $display("FAIL lock_errs: got ec=%h se=%b expected ec=00 se=0", bus.err_cnt, bus.seq_err);
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 1'b1, tb_rotl(i));
            n_checks++;
            if (bus.out_data !== 8'(i) || bus.seq_err !== 1'b0 || bus.locked !== 1'b1)
                $display("FAIL wrap[%0d]: got od=%h se=%b lk=%b expected od=%h se=0 lk=1",
                         i, bus.out_data, bus.seq_err, bus.locked, i);
            else n_pass++;
        end
    endtask

    task automatic test_single_error();
        drive_cycle(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (bus.seq_err !== 1'b1 || bus.locked !== 1'b1 || bus.err_cnt !== (ERRC_EN ? 8'h01 : 8'h00))
            $display("FAIL single_err: got se=%b lk=%b ec=%h expected se=1 lk=1 ec=%h",
                     bus.seq_err, bus.locked, bus.err_cnt, (ERRC_EN ? 8'h01 : 8'h00));
        else n_pass++;
        drive_cycle(1'b0, 1'b1, tb_rotl(8'h03));
        n_checks++;
        if (bus.seq_err !== 1'b0 || bus.locked !== 1'b1 || bus.out_data !== 8'h03)
            $display("FAIL single_err_recover: got se=%b lk=%b od=%h expected se=0 lk=1 od=03",
                     bus.seq_err, bus.locked, bus.out_data);
        else n_pass++;
    endtask

    task automatic test_loss_relock();
        int base;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, 8'h00);
            n_checks++;
            if (bus.seq_err !== 1'b1 || bus.locked !== (i < 2))
                $display("FAIL loss[%0d]: got se=%b lk=%b expected se=1 lk=%b",
                         i, bus.seq_err, bus.locked, (i < 2));
            else n_pass++;
        end
        n_checks++;
        if (bus.err_cnt !== 8'(m_err) || bus.err_cnt !== (ERRC_EN ? 8'h04 : 8'h00))
            $display("FAIL loss_errcnt: got %h expected %h", bus.err_cnt, (ERRC_EN ? 8'h04 : 8'h00));
        else n_pass++;
        base = $urandom_range(0, 255);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b1, tb_rotl((base + i) % 256));
            n_checks++;
            if (bus.out_data !== 8'((base + i) % 256) || bus.locked !== (i == 3) || bus.seq_err !== 1'b0)
                $display("FAIL relock[%0d]: got od=%h lk=%b se=%b expected od=%h lk=%b se=0",
                         i, bus.out_data, bus.locked, bus.seq_err, (base + i) % 256, (i == 3));
            else n_pass++;
        end
    endtask

    task automatic test_gap_valid();
        int base;
        bit v;
        drive_cycle(1'b1, 1'b0, 0);
        base = $urandom_range(0, 255);
        for (int k = 0; k < 8; k++) begin
            v = (k % 2 == 0);
            drive_cycle(1'b0, v, v ? tb_rotl((base + k / 2) % 256) : int'($urandom_range(0, 255)));
            n_checks++;
            if (bus.out_valid !== v || bus.locked !== (k >= 6) ||
                (v && bus.out_data !== 8'((base + k / 2) % 256)))
                $display("FAIL gap[%0d]: got ov=%b lk=%b od=%h expected ov=%b lk=%b od=%h",
                         k, bus.out_valid, bus.locked, bus.out_data, v, (k >= 6), (base + k / 2) % 256);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midstream();
        int d;
        drive_cycle(1'b0, 1'b1, tb_rotl((m_exp + 128) % 256));
        n_checks++;
        if (bus.seq_err !== 1'b1 || bus.locked !== 1'b1 || bus.err_cnt !== 8'(m_err))
            $display("FAIL pre_reset_err: got se=%b lk=%b ec=%h expected se=1 lk=1 ec=%h",
                     bus.seq_err, bus.locked, bus.err_cnt, m_err);
        else n_pass++;
        drive_cycle(1'b1, 1'b1, tb_rotl(m_exp));
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.locked !== 1'b0 || bus.err_cnt !== 8'h00 || bus.seq_err !== 1'b0)
            $display("FAIL mid_reset: got ov=%b lk=%b ec=%h se=%b expected 0 0 00 0",
                     bus.out_valid, bus.locked, bus.err_cnt, bus.seq_err);
        else n_pass++;
        d = $urandom_range(0, 255);
        drive_cycle(1'b0, 1'b1, d);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(tb_rotr(d)) || bus.locked !== 1'b0)
            $display("FAIL post_reset_word: got ov=%b od=%h lk=%b expected ov=1 od=%h lk=0",
                     bus.out_valid, bus.out_data, bus.locked, tb_rotr(d));
        else n_pass++;
    endtask

    task automatic test_random();
        int  c;
        bit  v, r, bad;
        int  d;
        logic [18:0] got, want;
        c = $urandom_range(0, 255);
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 149) == 0);
            bad = ((i % 90) >= 60 && (i % 90) < 65) || ($urandom_range(0, 11) == 0);
            d   = bad ? int'($urandom_range(0, 255)) : tb_rotl(c);
            if (v && !bad) c = (c + 1) % 256;
            drive_cycle(r, v, d);
            got  = {bus.out_valid, bus.out_valid ? bus.out_data : 8'h00, bus.locked, bus.seq_err, bus.err_cnt};
            want = {m_ov, m_ov ? 8'(m_od) : 8'h00, (m_mode == 2), m_seq, 8'(m_err)};
            n_checks++;
            if (got !== want)
                $display("FAIL random[%0d]: got ov/od/lk/se/ec=%h expected %h", i, got, want);
            else n_pass++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_lock();
        test_wrap();
        test_single_error();
        test_loss_relock();
        test_gap_valid();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/word_unshift_rx.md
# word_unshift_rx

Receive-side counterpart of the word-shift transmitter: accepts rotated 8-bit words and undoes the rotation to recover the original word. It locks onto the transmitter's incrementing counter sequence and flags, counts and recovers from sequence errors. Sits directly after the link input in the regression designs, and its recovered words feed the downstream checker.

## Interface
- `W`, default 8: word width; fixed at 8 in this release.
- `ROT`, default 5: left-rotation amount applied by the transmitter, range 0..W-1.
- `SEED`, default 8'hfc: counter value the transmitter emits first after its reset.
- `LOCK_N`, default 4: consecutive matches required to enter LOCKED.
- `LOSS_N`, default 3: consecutive mismatches in LOCKED that force HUNT.
- `clk  in  1`: single clock; everything sampled on the rising edge.
- `rst  in  1`: reset, synchronous and active-high.
- `in_valid  in  1`: `in_data` carries a word this cycle; no backpressure.
- `in_data  in  W`: received word, equal to rotl(counter, ROT).
- `out_valid  out  1`: `out_data` holds a recovered word.
- `out_data  out  W`: recovered word, rotr(in_data, ROT).
- `locked  out  1`: state is LOCKED.
- `seq_err  out  1`: one-cycle pulse on a mismatch while LOCKED.
- `err_cnt  out  8`: saturating count of mismatches while LOCKED.

## Operation
- Recovery: rec = rotr(in_data, ROT) = (in_data >> ROT) | (in_data << (W-ROT)). Logical shifts only. ROT=0 is a pass-through.
- Registers: `exp` (W bits), `run` (3 bits), `state`.
- Every valid word produces a recovered output, whatever the state.
- HUNT, on a valid word:
  - exp <= rec+1 (mod 2^W), run <= 1, go to VERIFY.
  - If LOCK_N=1, go straight to LOCKED.
- VERIFY, on a valid word:
  - rec==exp: exp <= exp+1, run <= run+1. When run+1==LOCK_N, go to LOCKED and clear run.
  - Mismatch: re-seed exactly as in HUNT (exp <= rec+1, run <= 1) and stay in VERIFY.
- LOCKED, on a valid word:
  - exp <= exp+1 on every valid word, so the sequence keeps stepping through errors.
  - Match: run <= 0.
  - Mismatch: seq_err pulses, err_cnt increments (saturating at 8'hff), run <= run+1. When run+1==LOSS_N, go to HUNT and clear run.
- A cycle without `in_valid` changes no state.
- Wrap: exp increments modulo 2^W, so 8'hff is followed by 8'h00 and this is not an error.
- err_cnt is cleared only by reset. It does not clear on a HUNT re-entry.

## Timing
- Latency is 1 cycle: `in_valid`/`in_data` at cycle t produce `out_valid`/`out_data` at t+1.
- `locked` and `seq_err` update in the same cycle t+1.
- Back-to-back valid words are accepted every cycle, at full throughput.
- Reset values: out_valid=0, out_data=0, locked=0, seq_err=0, err_cnt=0, state=HUNT, exp=0, run=0.
- Reset mid-stream: the word presented in the same cycle as `rst` is discarded, and there is no out_valid for it on the next cycle.
- A valid word in the first cycle after reset is processed normally in HUNT.

## Configuration
- `WORD_UNSHIFT_ERRCNT_EN` defined: the err_cnt register and its saturating incrementer are built.
- Not defined: err_cnt is tied to 8'h00 and no counter flops are built. seq_err, lock and loss behaviour are unchanged.

## Structure
- Package `word_shift_pkg` holds:
  - the state enum `unshift_state_t` {HUNT, VERIFY, LOCKED};
  - the functions `rotl_w` and `rotr_w`, shared with the transmitter model;
  - the localparam `WS_SEED = 8'hfc`.
- One sub-module, `word_rotr`: a combinational right-rotator parameterised on W and ROT, instantiated once for rec.

## Test plan
- Reset, then feed 8'h9f, 8'hbf, then the rotl5 images of 8'hfe and 8'hff:
  - out_data reads 8'hfc, 8'hfd, 8'hfe, 8'hff;
  - locked rises at the 4th output, with err_cnt=0.
- Once locked, continue the sequence through 8'hff → 8'h00 → 8'h01:
  - no seq_err;
  - out_data increments across the wrap.
- Once locked, corrupt one word (send 8'h00 in place of rotl5(exp)):
  - a single seq_err pulse, err_cnt=1, locked stays 1;
  - the next correct word matches, because exp kept stepping.
- Once locked, send 3 consecutive corrupt words:
  - err_cnt=3, locked drops at the 3rd output;
  - 4 fresh sequential words relock the block.
- Toggle in_valid as 1,0,1,0 across a lock sequence: lock still occurs after the 4th valid word, and out_valid mirrors in_valid delayed by 1 cycle.
- Assert rst together with a valid word while locked: next cycle out_valid=0, locked=0, err_cnt=0. Repeat the test with `WORD_UNSHIFT_ERRCNT_EN` undefined and check err_cnt stays 8'h00 under errors.
